// File: rtl/doce_tx_pkg.sv
// Shared state encoding and Ethernet/DoCE header layout for the multi-channel Tx framer.
package doce_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_e;

    // Byte offsets inside the header beat; byte 0 is tdata[7:0].
    localparam int DMAC_OFF  = 0;
    localparam int SMAC_OFF  = 6;
    localparam int ETYPE_OFF = 12;
    localparam int CH_OFF    = 14;
    localparam int CONN_OFF  = 15;
    localparam int HDR_BYTES = 16;

endpackage

// File: rtl/doce_rr_arbiter.sv
// Round-robin request picker: first requester at or above the pointer, wrapping.
module doce_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    logic [CH_W-1:0] c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = '0;
        // Scan offsets far-to-near so the requester closest to the pointer wins last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = CH_W'((int'(ptr_i) + k) % NUM_CH);
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = c;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/doce_tx_mux_framer.sv
// Multi-channel DoCE Tx path: round-robin packet mux, header prepend, registered AXI-Stream out.
// Optional per-channel framed packet counters (pkt_cnt) when DOCE_TX_PKT_CNT_EN is defined.
module doce_tx_mux_framer
    import doce_tx_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          NUM_CH     = 4,
    parameter int          NUM_CONN   = 16,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [NUM_CH*DATA_WIDTH*8-1:0]       s_axis_tdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         s_axis_tkeep,
    input  logic [NUM_CH*$clog2(NUM_CONN)-1:0]   s_axis_tuser,
    input  logic [NUM_CH-1:0]                    s_axis_tlast,
    input  logic [NUM_CH-1:0]                    s_axis_tvalid,
    output logic [NUM_CH-1:0]                    s_axis_tready,
    output logic [DATA_WIDTH*8-1:0]              m_axis_tdata,
    output logic [DATA_WIDTH-1:0]                m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    input  logic                                 cfg_we,
    input  logic [$clog2(NUM_CONN)-1:0]          cfg_addr,
    input  logic [47:0]                          cfg_mac,
    input  logic [47:0]                          src_mac_addr,
    output logic                                 drop_pulse
`ifdef DOCE_TX_PKT_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]                 pkt_cnt
`endif
);

    localparam int DW8    = DATA_WIDTH * 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CONN_W = $clog2(NUM_CONN);

    state_e              state_q;
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     rr_d;
    logic [CH_W-1:0]     gidx_q;
    logic [NUM_CH-1:0]   gnt_q;
    logic [CONN_W-1:0]   conn_q;
    logic [47:0]         dmac_q;

    logic [47:0]         tmac_q [NUM_CONN];
    logic [NUM_CONN-1:0] tvld_q;

    logic [NUM_CH-1:0][DW8-1:0]        s_data;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] s_keep;
    logic [NUM_CH-1:0][CONN_W-1:0]     s_user;

    assign s_data = s_axis_tdata;
    assign s_keep = s_axis_tkeep;
    assign s_user = s_axis_tuser;

    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;

    doce_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i  (s_axis_tvalid),
        .ptr_i  (rr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    logic [CONN_W-1:0]     sel_tuser;
    logic [DW8-1:0]        cur_data;
    logic [DATA_WIDTH-1:0] cur_keep;
    logic                  cur_last;
    logic                  cur_valid;
    logic                  out_room;
    logic                  hdr_load;
    logic                  beat_load;
    logic [DW8-1:0]        hdr;

    assign sel_tuser = s_user[arb_idx];
    assign cur_data  = s_data[gidx_q];
    assign cur_keep  = s_keep[gidx_q];
    assign cur_last  = s_axis_tlast[gidx_q];
    assign cur_valid = s_axis_tvalid[gidx_q];
    assign out_room  = !m_axis_tvalid || m_axis_tready;
    assign hdr_load  = (state_q == HDR) && out_room;
    assign beat_load = (state_q == DATA) && cur_valid && out_room;
    assign rr_d      = (gidx_q == CH_W'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        s_axis_tready = '0;
        if (state_q == DATA) begin
            s_axis_tready = gnt_q & {NUM_CH{out_room}};
        end else if (state_q == DROP) begin
            s_axis_tready = gnt_q;
        end
    end

    // Header beat; anything past the 16 defined bytes stays zero.
    always_comb begin
        hdr = '0;
        for (int i = 0; i < 6; i++) begin
            hdr[8*(DMAC_OFF+i) +: 8] = dmac_q[8*(5-i) +: 8];
            hdr[8*(SMAC_OFF+i) +: 8] = src_mac_addr[8*(5-i) +: 8];
        end
        hdr[8*ETYPE_OFF +: 8]     = ETH_TYPE[15:8];
        hdr[8*(ETYPE_OFF+1) +: 8] = ETH_TYPE[7:0];
        hdr[8*CH_OFF +: 8]        = 8'(gidx_q);
        hdr[8*CONN_OFF +: 8]      = 8'(conn_q);
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tmac_q[cfg_addr] <= cfg_mac;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tvld_q <= '0;
        end else if (cfg_we) begin
            tvld_q[cfg_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            gidx_q        <= '0;
            gnt_q         <= '0;
            conn_q        <= '0;
            dmac_q        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            drop_pulse    <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            // A consumed beat empties the register unless a new one is loaded below.
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gidx_q  <= arb_idx;
                        gnt_q   <= arb_gnt;
                        conn_q  <= sel_tuser;
                        dmac_q  <= tmac_q[sel_tuser];
                        state_q <= tvld_q[sel_tuser] ? HDR : DROP;
                    end
                end
                HDR: begin
                    if (hdr_load) begin
                        m_axis_tdata  <= hdr;
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (beat_load) begin
                        m_axis_tdata  <= cur_data;
                        m_axis_tkeep  <= cur_keep;
                        m_axis_tlast  <= cur_last;
                        m_axis_tvalid <= 1'b1;
                        if (cur_last) begin
                            rr_q    <= rr_d;
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (cur_valid && cur_last) begin
                        drop_pulse <= 1'b1;
                        rr_q       <= rr_d;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DOCE_TX_PKT_CNT_EN
    // The last beat may sit in the output register after the grant moves on, so track its owner.
    logic [CH_W-1:0]         out_ch_q;
    logic [NUM_CH-1:0][31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_ch_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (beat_load) begin
                out_ch_q <= gidx_q;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                cnt_q[out_ch_q] <= cnt_q[out_ch_q] + 32'd1;
            end
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_doce_tx_mux_framer.sv
// Directed self-checking bench for doce_tx_mux_framer (4 channels, 16-byte beats).
`timescale 1ns/1ps
module tb_doce_tx_mux_framer;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0][DW*8-1:0] td;
    logic [NCH-1:0][DW-1:0]   tk;
    logic [NCH-1:0][CW-1:0]   tu;
    logic [NCH-1:0]           tl, tv, s_ready;
    logic [DW*8-1:0]          m_data;
    logic [DW-1:0]            m_keep;
    logic                     m_last, m_valid, m_ready;
    logic                     cfg_we;
    logic [CW-1:0]            cfg_addr;
    logic [47:0]              cfg_mac, src_mac;
    logic                     drop;
`ifdef DOCE_TX_PKT_CNT_EN
    logic [NCH*32-1:0]        pkt_cnt;
`endif

    doce_tx_mux_framer #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .NUM_CONN   (16),
        .ETH_TYPE   (16'h88B5)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (td),
        .s_axis_tkeep  (tk),
        .s_axis_tuser  (tu),
        .s_axis_tlast  (tl),
        .s_axis_tvalid (tv),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_mac       (cfg_mac),
        .src_mac_addr  (src_mac),
        .drop_pulse    (drop)
`ifdef DOCE_TX_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    typedef struct {
        logic [DW*8-1:0] d;
        logic [DW-1:0]   k;
        logic            l;
        int              cyc;
    } beat_t;

    beat_t obs[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    drops = 0;
    int    acc [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    // Output handshakes, drop pulses and input acceptances, sampled mid-cycle.
    always @(negedge clk) begin
        if (aresetn) begin
            if (m_valid && m_ready) obs.push_back('{m_data, m_keep, m_last, cyc});
            if (drop) drops++;
            for (int i = 0; i < NCH; i++) if (tv[i] && s_ready[i]) acc[i]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*8-1:0] mk(input int ch, input int p, input int b);
        return {4{ch[7:0], p[7:0], b[7:0], 8'h5A}};
    endfunction

    function automatic logic [47:0] mac_of(input int i);
        return {40'hAABBCCDDEE, i[7:0]};
    endfunction

    function automatic logic [DW*8-1:0] exp_hdr(input logic [47:0] dm, input logic [47:0] sm,
                                                 input int ch, input int conn);
        logic [DW*8-1:0] h;
        h = '0;
        for (int i = 0; i < 6; i++) begin
            h[8*i +: 8]     = dm[8*(5-i) +: 8];
            h[8*(6+i) +: 8] = sm[8*(5-i) +: 8];
        end
        h[103:96]  = 8'h88;
        h[111:104] = 8'hB5;
        h[119:112] = ch[7:0];
        h[127:120] = conn[7:0];
        return h;
    endfunction

    task automatic do_reset();
        aresetn = 1'b0;
        tv = '0;
        tl = '0;
        cfg_we = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic cfg_write(input int a, input logic [47:0] mac);
        cfg_we = 1'b1;
        cfg_addr = CW'(a);
        cfg_mac = mac;
        step();
        cfg_we = 1'b0;
    endtask

    // Last beat of each packet carries keep 00FF so tkeep passthrough is visible.
    task automatic drive_pkts(input int ch, input int npkt, input int nb, input int user, input int tag);
        int n;
        for (int p = 0; p < npkt; p++) begin
            for (int b = 0; b < nb; b++) begin
                tv[ch] = 1'b1;
                td[ch] = mk(ch, tag + p, b);
                tk[ch] = (b == nb - 1) ? 16'h00FF : 16'hFFFF;
                tl[ch] = (b == nb - 1);
                tu[ch] = CW'(user);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!s_ready[ch] && n < 200);
                if (!s_ready[ch]) begin
                    checks++;
                    errors++;
                    $display("FAIL drive_timeout ch%0d: tready %b, required 1", ch, s_ready[ch]);
                    tv[ch] = 1'b0;
                    tl[ch] = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        tv[ch] = 1'b0;
        tl[ch] = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        step();
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_data); end
        checks++; if (m_keep !== '0) begin errors++; $display("FAIL rst_tkeep: got %h want 0", m_keep); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_last); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_tready: got %b want 0000", s_ready); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b want 0", drop); end
        aresetn = 1'b1;
    endtask

    task automatic test_header();
        logic [DW*8-1:0] want_hdr;
        want_hdr = 128'h0301B588_66554433_22110F0E_0D0C0B0A;
        do_reset();
        src_mac = 48'h112233445566;
        cfg_write(3, 48'h0A0B0C0D0E0F);
        tv[1] = 1'b1; td[1] = mk(1, 0, 0); tk[1] = 16'hFFFF; tl[1] = 1'b0; tu[1] = 4'd3;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hdr_arb_cycle: tvalid %b want 0", m_valid); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL hdr_arb_tready: got %b want 0000", s_ready); end
        step();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL hdr_latency: tvalid %b want 1", m_valid); end
        checks++;
        if ({m_data, m_keep, m_last} !== {want_hdr, 16'hFFFF, 1'b0}) begin
            errors++; $display("FAIL hdr_beat: got %h/%h/%b want %h/ffff/0", m_data, m_keep, m_last, want_hdr);
        end
        checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL hdr_data_tready: got %b want 0010", s_ready); end
        step();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, mk(1, 0, 0), 16'hFFFF, 1'b0}) begin
            errors++; $display("FAIL hdr_pay0: got %b/%h/%h/%b", m_valid, m_data, m_keep, m_last);
        end
        td[1] = mk(1, 0, 1);
        step();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, mk(1, 0, 1), 16'hFFFF, 1'b0}) begin
            errors++; $display("FAIL hdr_pay1: got %b/%h/%h/%b", m_valid, m_data, m_keep, m_last);
        end
        td[1] = mk(1, 0, 2); tk[1] = 16'h00FF; tl[1] = 1'b1;
        step();
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, mk(1, 0, 2), 16'h00FF, 1'b1}) begin
            errors++; $display("FAIL hdr_pay2_last: got %b/%h/%h/%b", m_valid, m_data, m_keep, m_last);
        end
        tv[1] = 1'b0; tl[1] = 1'b0;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hdr_drain: tvalid %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        beat_t ex[$];
        int order [5] = '{0, 1, 2, 3, 0};
        int tags  [5] = '{10, 20, 30, 40, 11};
        do_reset();
        for (int i = 0; i < 4; i++) cfg_write(i, mac_of(i));
        obs.delete();
        fork
            drive_pkts(0, 2, 2, 0, 10);
            drive_pkts(1, 1, 2, 1, 20);
            drive_pkts(2, 1, 2, 2, 30);
            drive_pkts(3, 1, 2, 3, 40);
        join
        repeat (3) step();
        for (int p = 0; p < 5; p++) begin
            ex.push_back('{exp_hdr(mac_of(order[p]), src_mac, order[p], order[p]), 16'hFFFF, 1'b0, 0});
            ex.push_back('{mk(order[p], tags[p], 0), 16'hFFFF, 1'b0, 0});
            ex.push_back('{mk(order[p], tags[p], 1), 16'h00FF, 1'b1, 0});
        end
        checks++; if (obs.size() != 15) begin errors++; $display("FAIL b2b_count: got %0d beats want 15", obs.size()); end
        for (int i = 0; i < 15 && i < obs.size(); i++) begin
            checks++;
            if ({obs[i].d, obs[i].k, obs[i].l} !== {ex[i].d, ex[i].k, ex[i].l}) begin
                errors++; $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b",
                                   i, obs[i].d, obs[i].k, obs[i].l, ex[i].d, ex[i].k, ex[i].l);
            end
        end
        for (int p = 1; p < 5 && 3 * p < obs.size(); p++) begin
            checks++;
            if (obs[3*p].cyc - obs[3*(p-1)].cyc != 4) begin
                errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", p, obs[3*p].cyc - obs[3*(p-1)].cyc);
            end
        end
    endtask

    task automatic test_drop();
        int d0, a0, c0;
        obs.delete();
        d0 = drops;
        a0 = acc[2];
        drive_pkts(2, 1, 4, 5, 50);
        repeat (3) step();
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL drop_no_out: got %0d beats want 0", obs.size()); end
        checks++; if (drops - d0 != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses want 1", drops - d0); end
        checks++; if (acc[2] - a0 != 4) begin errors++; $display("FAIL drop_consumed: got %0d beats want 4", acc[2] - a0); end
        d0 = drops;
        c0 = cyc;
        drive_pkts(3, 1, 1, 7, 55);
        checks++; if (cyc - c0 != 2) begin errors++; $display("FAIL drop_single_time: got %0d cycles want 2", cyc - c0); end
        repeat (3) step();
        checks++; if (drops - d0 != 1) begin errors++; $display("FAIL drop_single_pulse: got %0d want 1", drops - d0); end
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL drop_single_out: got %0d beats want 0", obs.size()); end
    endtask

    task automatic test_backpressure();
        beat_t ex[$];
        obs.delete();
        fork
            drive_pkts(0, 1, 4, 0, 60);
            begin : tog
                logic pv, pr;
                logic [DW*8-1:0] pd;
                pv = 1'b0; pr = 1'b1; pd = '0;
                for (int i = 0; i < 24; i++) begin
                    m_ready = (i % 2 == 0);
                    @(negedge clk);
                    if (pv && !pr) begin
                        checks++;
                        if (m_valid !== 1'b1 || m_data !== pd) begin
                            errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", i, m_valid, m_data, pd);
                        end
                    end
                    pv = m_valid; pr = m_ready; pd = m_data;
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        repeat (3) step();
        ex.push_back('{exp_hdr(mac_of(0), src_mac, 0, 0), 16'hFFFF, 1'b0, 0});
        for (int b = 0; b < 4; b++) ex.push_back('{mk(0, 60, b), (b == 3) ? 16'h00FF : 16'hFFFF, b == 3, 0});
        checks++; if (obs.size() != 5) begin errors++; $display("FAIL bp_count: got %0d beats want 5", obs.size()); end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            checks++;
            if ({obs[i].d, obs[i].k, obs[i].l} !== {ex[i].d, ex[i].k, ex[i].l}) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%h/%b want %h/%h/%b",
                                   i, obs[i].d, obs[i].k, obs[i].l, ex[i].d, ex[i].k, ex[i].l);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0, c0;
        m_ready = 1'b1;
        tv[1] = 1'b1; td[1] = mk(1, 70, 0); tk[1] = 16'hFFFF; tl[1] = 1'b0; tu[1] = 4'd1;
        step(); step(); step();
        td[1] = mk(1, 70, 1);
        step();
        aresetn = 1'b0;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL midrst_tdata: got %h want 0", m_data); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL midrst_tready: got %b want 0000", s_ready); end
        aresetn = 1'b1;
        tv[1] = 1'b0;
        obs.delete();
        d0 = drops;
        cfg_write(1, 48'h665544332211);
        c0 = cyc;
        fork
            drive_pkts(0, 1, 2, 1, 80);
            drive_pkts(1, 1, 1, 2, 90);
        join
        repeat (3) step();
        checks++; if (obs.size() != 3) begin errors++; $display("FAIL midrst_count: got %0d beats want 3", obs.size()); end
        if (obs.size() == 3) begin
            checks++;
            if (obs[0].d !== exp_hdr(48'h665544332211, src_mac, 0, 1)) begin
                errors++; $display("FAIL midrst_hdr: got %h", obs[0].d);
            end
            checks++;
            if (obs[0].cyc - c0 != 2) begin
                errors++; $display("FAIL midrst_rr0: header after %0d cycles want 2", obs[0].cyc - c0);
            end
            checks++;
            if ({obs[2].d, obs[2].k, obs[2].l} !== {mk(0, 80, 1), 16'h00FF, 1'b1}) begin
                errors++; $display("FAIL midrst_last: got %h/%h/%b", obs[2].d, obs[2].k, obs[2].l);
            end
        end
        checks++; if (drops - d0 != 1) begin errors++; $display("FAIL midrst_stale_entry: got %0d drops want 1", drops - d0); end
    endtask

    task automatic test_pkt_cnt();
`ifdef DOCE_TX_PKT_CNT_EN
        do_reset();
        cfg_write(0, mac_of(0));
        drive_pkts(0, 5, 2, 0, 100);
        drive_pkts(0, 1, 1, 9, 110);
        repeat (4) step();
        checks++; if (pkt_cnt[31:0] !== 32'd5) begin errors++; $display("FAIL pkt_cnt0: got %0d want 5", pkt_cnt[31:0]); end
        checks++; if (pkt_cnt[63:32] !== 32'd0) begin errors++; $display("FAIL pkt_cnt1: got %0d want 0", pkt_cnt[63:32]); end
`endif
    endtask

    initial begin
        td = '0; tk = '0; tu = '0; tl = '0; tv = '0;
        m_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_mac = '0;
        src_mac = '0;
        test_reset();
        test_header();
        test_back_to_back();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_pkt_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/doce_tx_mux_framer.md
Name: doce_tx_mux_framer

Overview:
Multi-channel successor to the single-stream DoCE transport Tx path. Accepts NUM_CH transaction-layer AXI-Stream channels and arbitrates between them round-robin at packet granularity. Prepends one Ethernet/DoCE header beat per packet, using a destination MAC taken from an internal per-connection table. Drives one registered AXI-Stream output toward the DoCE MAC.

Parameters:
DATA_WIDTH, 16, stream width in bytes; legal values 16, 32, 64.
NUM_CH, 4, number of input channels; 2..8.
NUM_CONN, 16, destination MAC table entries; power of 2.
ETH_TYPE, 16'h88B5, ethertype placed in the header.

Ports:
clk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_tdata  in  NUM_CH*DATA_WIDTH*8  per-channel payload; channel i at slice i
s_axis_tkeep  in  NUM_CH*DATA_WIDTH  per-channel byte enables
s_axis_tuser  in  NUM_CH*$clog2(NUM_CONN)  per-channel connection id; sampled on first beat
s_axis_tlast  in  NUM_CH  per-channel end of packet
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tready  out  NUM_CH  per-channel ready
m_axis_tdata  out  DATA_WIDTH*8  framed output data
m_axis_tkeep  out  DATA_WIDTH  framed output keep
m_axis_tlast  out  1  framed output last
m_axis_tvalid  out  1  framed output valid
m_axis_tready  in  1  framed output ready
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(NUM_CONN)  table index
cfg_mac  in  48  destination MAC; entry marked valid on write
src_mac_addr  in  48  local MAC; quasi-static
drop_pulse  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset (aresetn low at clk edge): state IDLE; rr pointer 0; all table valid bits 0; m_axis_tvalid 0; m_axis_tdata/tkeep/tlast 0; s_axis_tready 0; drop_pulse 0. Reset mid-packet abandons the packet; no tlast is emitted.
- State IDLE:
  - Grant the first channel with tvalid=1, searching from the rr pointer upward with wrap.
  - Latch the grant index and tuser, then look up the table.
  - Valid entry -> HDR. Invalid entry -> DROP.
  - Arbitration takes 1 cycle.
- State HDR:
  - Load the output register with the header beat when it is empty or draining (!m_axis_tvalid || m_axis_tready).
  - Header bytes, byte 0 = tdata[7:0]:
    - bytes 0-5: dst MAC, MSB first.
    - bytes 6-11: src_mac_addr, MSB first.
    - bytes 12-13: ETH_TYPE, MSB first.
    - byte 14: channel index.
    - byte 15: connection id.
    - bytes 16 and up: zero.
  - Header beat has tkeep all ones and tlast 0. Then -> DATA.
- State DATA:
  - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready); all other channels' tready = 0.
  - Beats pass through unchanged into the output register.
  - On the accepted input beat with tlast=1: rr pointer = g+1 mod NUM_CH, then -> IDLE.
- State DROP:
  - s_axis_tready[g] = 1; beats are discarded.
  - On the accepted tlast beat: drop_pulse = 1 for one cycle, rr pointer advances, then -> IDLE.
  - A single-beat packet (tlast on the first beat) drops in one cycle.
- Output register:
  - Holds its contents while m_axis_tvalid && !m_axis_tready; AXI-Stream stability rules apply.
  - Full throughput: 1 beat per cycle in DATA.
  - Per-packet overhead: 1 arbitration cycle + 1 header cycle.
- Table:
  - A cfg_we write lands on the next clk edge.
  - A write to the index being looked up in the same cycle is not seen; the old value is used.
  - Rewriting an entry updates it; entries cannot be invalidated except by reset.
- Latency: the first input tvalid in IDLE produces the header on m_axis_tvalid 2 cycles later, with an idle output.
- A channel raising tvalid mid-grant waits; no preemption. Fairness: each channel is served at most once per NUM_CH grants while others are pending.

Optional Feature:
DOCE_TX_PKT_CNT_EN.
- Defined: adds output port pkt_cnt, NUM_CH*32 bits.
  - Counter i increments when channel i's framed packet tlast beat leaves m_axis.
  - Drops are not counted; counters wrap at 2^32; reset to 0.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package doce_tx_pkg: state enum (IDLE, HDR, DATA, DROP), header byte offsets (DMAC_OFF=0, SMAC_OFF=6, ETYPE_OFF=12, CH_OFF=14, CONN_OFF=15), HDR_BYTES=16.
- Natural sub-module: doce_rr_arbiter, a NUM_CH request vector plus pointer producing a one-hot grant and index.

Test Plan:
- Table[3]=0x0A0B0C0D0E0F, src=0x112233445566, ch1 sends a 3-beat packet with tuser=3 -> header bytes 0-15 = 0A 0B 0C 0D 0E 0F 11 22 33 44 55 66 88 B5 01 03, then 3 payload beats unchanged, tlast on the 4th output beat.
- All 4 channels hold back-to-back 2-beat packets, tready=1 -> grant order 0,1,2,3,0; 3 output beats per packet plus 1 idle cycle each.
- ch2 tuser=5 with entry 5 never written, 4-beat packet -> no m_axis_tvalid, 4 input beats consumed, drop_pulse high exactly once.
- m_axis_tready toggled 1010 during DATA -> no beat lost or duplicated; tdata stable while stalled.
- aresetn low for 1 cycle mid-payload, then entry rewritten and a packet sent -> m_axis_tvalid=0 after reset, next packet is framed fresh from rr pointer 0.
- With DOCE_TX_PKT_CNT_EN, 5 packets on ch0 and 1 dropped -> pkt_cnt[31:0]=5.
